// File: rtl/md5_candidate_gen.sv
// Odometer-order brute-force candidate generator feeding the MD5 pipeline core.
// Optional `CANDGEN_COUNT_EN builds the 64-bit emitted-candidate counter; otherwise count is tied to zero.
module md5_candidate_gen #(
   parameter int         MAX_LEN    = 8,
   parameter logic [7:0] CHAR_FIRST = 8'h61,
   parameter int         CHAR_COUNT = 26
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         halt,
   input  logic [5:0]   max_len,
   output logic [447:0] message,
   output logic [63:0]  length,
   output logic         valid,
   output logic         busy,
   output logic         done,
   output logic [63:0]  count
);
   // state  | meaning
   // S_IDLE | reset state, outputs zero
   // S_RUN  | emitting one candidate per un-halted cycle
   // S_DONE | enumeration exhausted, last candidate held
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam int            DW       = (CHAR_COUNT > 2) ? $clog2(CHAR_COUNT) : 1;
   localparam logic [DW-1:0] DIG_MAX  = DW'(CHAR_COUNT - 1);
   localparam logic [5:0]    MAX_LEN6 = 6'(MAX_LEN);

   logic [1:0]                  state;
   logic [MAX_LEN-1:0][DW-1:0]  dig;
   logic [MAX_LEN-1:0][DW-1:0]  dig_nxt;
   logic [5:0]                  n_cur;
   logic [5:0]                  n_nxt;
   logic [5:0]                  lim;
   logic [5:0]                  lim_in;
   logic [MAX_LEN-1:0]          at_max;
   logic [MAX_LEN-1:0]          in_len;
   logic [MAX_LEN-1:0]          carry;
   logic                        c_acc;
   logic                        wrap_all;
   logic                        last_cand;
   logic [447:0]                msg_nxt;

   assign lim_in = (max_len == 6'd0 || max_len > MAX_LEN6) ? MAX_LEN6 : max_len;

   // Carry into digit i is a flat AND of the at-max flags below it, never a ripple through adders.
   always_comb begin
      at_max = '0;
      in_len = '0;
      carry  = '0;
      c_acc  = 1'b1;
      for (int i = 0; i < MAX_LEN; i++) begin
         at_max[i] = (dig[i] == DIG_MAX);
         in_len[i] = (6'(i) < n_cur);
      end
      for (int i = 0; i < MAX_LEN; i++) begin
         c_acc = 1'b1;
         for (int j = 0; j < i; j++) c_acc = c_acc & at_max[j];
         carry[i] = c_acc;
      end
   end

   assign wrap_all  = &(at_max | ~in_len);
   assign last_cand = wrap_all && (n_cur >= lim);

   always_comb begin
      n_nxt   = n_cur;
      dig_nxt = dig;
      if (wrap_all) begin
         if (n_cur < lim) n_nxt = n_cur + 6'd1;
         dig_nxt = '0;
      end else begin
         for (int i = 0; i < MAX_LEN; i++) begin
            if (carry[i] && in_len[i]) dig_nxt[i] = at_max[i] ? '0 : dig[i] + DW'(1);
         end
      end
   end

   always_comb begin
      msg_nxt = '0;
      for (int i = 0; i < MAX_LEN; i++) begin
         msg_nxt[8*i +: 8] = (6'(i) < n_nxt) ? CHAR_FIRST + 8'(dig_nxt[i]) : 8'h00;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         dig     <= '0;
         n_cur   <= 6'd0;
         lim     <= 6'd0;
         message <= '0;
         length  <= '0;
         valid   <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         valid <= 1'b0;
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state   <= S_RUN;
                  lim     <= lim_in;
                  n_cur   <= 6'd1;
                  dig     <= '0;
                  message <= {440'd0, CHAR_FIRST};
                  length  <= 64'd8;
                  valid   <= 1'b1;
                  busy    <= 1'b1;
                  done    <= 1'b0;
               end
            end
            S_RUN: begin
               if (!halt) begin
                  if (last_cand) begin
                     state <= S_DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     dig     <= dig_nxt;
                     n_cur   <= n_nxt;
                     message <= msg_nxt;
                     length  <= {55'd0, n_nxt, 3'd0};
                     valid   <= 1'b1;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef CANDGEN_COUNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if ((state == S_IDLE || state == S_DONE) && start) begin
         count <= '0;
      end else if (valid) begin
         count <= count + 64'd1;
      end
   end
`else
   assign count = '0;
`endif

endmodule

// File: tb/tb_md5_candidate_gen.sv
// Self-checking bench for md5_candidate_gen: randomized halts/noise against an ordinal-based string model.
module tb_md5_candidate_gen;
   localparam int         CC = 26;
   localparam logic [7:0] CF = 8'h61;
`ifdef CANDGEN_COUNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst, start, halt, sel;
   logic [5:0]   max_len;
   logic [447:0] msg_a, msg_b, o_msg;
   logic [63:0]  len_a, len_b, o_len, cnt_a, cnt_b, o_cnt;
   logic         val_a, val_b, o_valid, busy_a, busy_b, o_busy, done_a, done_b, o_done;
   int           total_n = 0;
   int           bad_n   = 0;

   always #5 clk = ~clk;

   md5_candidate_gen dut_a (
      .clk(clk), .rst(rst), .start(start & ~sel), .halt(halt), .max_len(max_len),
      .message(msg_a), .length(len_a), .valid(val_a), .busy(busy_a), .done(done_a), .count(cnt_a)
   );

   md5_candidate_gen #(.MAX_LEN(2)) dut_b (
      .clk(clk), .rst(rst), .start(start & sel), .halt(halt), .max_len(max_len),
      .message(msg_b), .length(len_b), .valid(val_b), .busy(busy_b), .done(done_b), .count(cnt_b)
   );

   assign o_msg   = sel ? msg_b  : msg_a;
   assign o_len   = sel ? len_b  : len_a;
   assign o_cnt   = sel ? cnt_b  : cnt_a;
   assign o_valid = sel ? val_b  : val_a;
   assign o_busy  = sel ? busy_b : busy_a;
   assign o_done  = sel ? done_b : done_a;

   // Candidate with ordinal idx (0-based over the whole enumeration), derived from base-CC arithmetic.
   function automatic void cand(input longint unsigned idx, output logic [447:0] msg,
                                output logic [63:0] len);
      longint unsigned k = idx;
      longint unsigned p = CC;
      int              l = 1;
      while (k >= p) begin
         k = k - p;
         p = p * CC;
         l++;
      end
      msg = '0;
      for (int i = 0; i < l; i++) begin
         msg[8*i +: 8] = 8'(longint'(CF) + k % CC);
         k = k / CC;
      end
      len = 64'(8 * l);
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; start = 1'b0; halt = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic run_seq(input bit dsel, input int m, input int halt_pct, input int halt_at,
                          input int abort_cyc, input bit start_halt, input bit noise, input string tag);
      int              maxl, lim, hold_left, bound;
      longint unsigned total, p, nidx, cv;
      logic [447:0]    lmsg;
      logic [63:0]     llen, ecnt;
      bit              hprev, ev, fin, err, hold_used;
      maxl  = dsel ? 2 : 8;
      lim   = (m == 0 || m > maxl) ? maxl : m;
      total = 0;
      p     = 1;
      for (int k = 1; k <= lim; k++) begin
         p     = p * CC;
         total = total + p;
      end
      bound = int'(total) * 4 + 100;
      @(negedge clk);
      sel = dsel; max_len = 6'(m); start = 1'b1; halt = start_halt;
      hprev = 1'b0; nidx = 0; cv = 0; fin = 1'b0; err = 1'b0;
      hold_left = 0; hold_used = 1'b0; lmsg = '0; llen = '0;
      for (int cyc = 0; cyc < bound && !fin && !err; cyc++) begin
         @(negedge clk);
         ev = 1'b0;
         if (hprev) ev = 1'b0;
         else if (nidx == total) fin = 1'b1;
         else begin
            cand(nidx, lmsg, llen);
            nidx++;
            ev = 1'b1;
         end
         ecnt = CNT_EN ? 64'(cv) : 64'd0;
         total_n += 5;
         if (o_valid !== ev) begin
            bad_n++; err = 1'b1;
            $display("FAIL %s valid at ordinal %0d: got %b want %b", tag, nidx, o_valid, ev);
         end
         if ({o_busy, o_done} !== {!fin, fin}) begin
            bad_n++; err = 1'b1;
            $display("FAIL %s busy/done at ordinal %0d: got %b%b want %b%b", tag, nidx, o_busy, o_done, !fin, fin);
         end
         if (o_msg !== lmsg) begin
            bad_n++; err = 1'b1;
            $display("FAIL %s message at ordinal %0d: got %h want %h", tag, nidx, o_msg, lmsg);
         end
         if (o_len !== llen) begin
            bad_n++; err = 1'b1;
            $display("FAIL %s length at ordinal %0d: got %0d want %0d", tag, nidx, o_len, llen);
         end
         if (o_cnt !== ecnt) begin
            bad_n++; err = 1'b1;
            $display("FAIL %s count at ordinal %0d: got %0d want %0d", tag, nidx, o_cnt, ecnt);
         end
         if (ev) cv++;
         if (!fin) begin
            start = noise && ($urandom_range(0, 9) == 0);
            if (noise) max_len = 6'($urandom);
            if (halt_at >= 0 && !hold_used && nidx == longint'(halt_at)) begin
               hold_left = 5;
               hold_used = 1'b1;
            end
            if (start_halt && cyc == 0) halt = 1'b1;
            else if (hold_left > 0) begin
               halt = 1'b1;
               hold_left--;
            end else halt = (halt_pct > 0) && ($urandom_range(0, 99) < halt_pct);
            hprev = halt;
            if (abort_cyc > 0 && cyc == abort_cyc) begin
               rst = 1'b1; halt = 1'b1; start = 1'b0;
               @(negedge clk);
               total_n += 3;
               if ({o_valid, o_busy, o_done} !== 3'b000) begin
                  bad_n++;
                  $display("FAIL %s flags after reset: got %b want 000", tag, {o_valid, o_busy, o_done});
               end
               if (o_msg !== '0 || o_len !== '0) begin
                  bad_n++;
                  $display("FAIL %s data after reset: got %h/%0d want 0/0", tag, o_msg, o_len);
               end
               if (o_cnt !== 64'd0) begin
                  bad_n++;
                  $display("FAIL %s count after reset: got %0d want 0", tag, o_cnt);
               end
               rst = 1'b0; halt = 1'b0;
               return;
            end
         end
      end
      start = 1'b0;
      if (!fin && !err) begin
         total_n++; bad_n++;
         $display("FAIL %s timeout: got %0d candidates want %0d", tag, nidx, total);
      end
      if (fin && !err) begin
         ecnt = CNT_EN ? 64'(cv) : 64'd0;
         for (int k = 0; k < 3; k++) begin
            halt = 1'($urandom_range(0, 1));
            @(negedge clk);
            total_n += 3;
            if ({o_valid, o_busy, o_done} !== 3'b001) begin
               bad_n++;
               $display("FAIL %s done hold flags: got %b want 001", tag, {o_valid, o_busy, o_done});
            end
            if (o_msg !== lmsg || o_len !== llen) begin
               bad_n++;
               $display("FAIL %s done hold data: got %h want %h", tag, o_msg, lmsg);
            end
            if (o_cnt !== ecnt) begin
               bad_n++;
               $display("FAIL %s done count: got %0d want %0d", tag, o_cnt, ecnt);
            end
         end
         halt = 1'b0;
      end
   endtask

   task automatic test_reset();
      sel = 1'b0; rst = 1'b1; start = 1'b1; halt = 1'($urandom_range(0, 1)); max_len = 6'($urandom);
      repeat (3) @(negedge clk);
      start = 1'b0;
      rst = 1'b0;
      for (int k = 0; k < 2; k++) begin
         total_n += 4;
         if ({o_valid, o_busy, o_done} !== 3'b000) begin
            bad_n++;
            $display("FAIL reset flags: got %b want 000", {o_valid, o_busy, o_done});
         end
         if (o_msg !== '0) begin
            bad_n++;
            $display("FAIL reset message: got %h want 0", o_msg);
         end
         if (o_len !== 64'd0) begin
            bad_n++;
            $display("FAIL reset length: got %0d want 0", o_len);
         end
         if (o_cnt !== 64'd0) begin
            bad_n++;
            $display("FAIL reset count: got %0d want 0", o_cnt);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_directed();
      logic [447:0] q_msg[$];
      logic [63:0]  q_len[$];
      logic [63:0]  cnt_done, ecnt;
      bit           got_done;
      do_reset();
      sel = 1'b0; max_len = 6'd2; start = 1'b1; halt = 1'b0;
      got_done = 1'b0; cnt_done = '0;
      for (int c = 0; c < 800 && !got_done; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (o_valid) begin
            q_msg.push_back(o_msg);
            q_len.push_back(o_len);
         end
         if (o_done) begin
            got_done = 1'b1;
            cnt_done = o_cnt;
         end
      end
      ecnt = CNT_EN ? 64'd702 : 64'd0;
      total_n += 3;
      if (!got_done) begin
         bad_n++;
         $display("FAIL directed done: got 0 want 1");
      end
      if (q_msg.size() != 702) begin
         bad_n++;
         $display("FAIL directed total: got %0d want 702", q_msg.size());
      end
      if (cnt_done !== ecnt) begin
         bad_n++;
         $display("FAIL directed count: got %0d want %0d", cnt_done, ecnt);
      end
      if (q_msg.size() == 702) begin
         total_n += 8;
         if (q_msg[0] !== 448'h61)      begin bad_n++; $display("FAIL directed first: got %h want 61", q_msg[0]); end
         if (q_msg[25] !== 448'h7a)     begin bad_n++; $display("FAIL directed z: got %h want 7a", q_msg[25]); end
         if (q_len[25] !== 64'd8)       begin bad_n++; $display("FAIL directed len1: got %0d want 8", q_len[25]); end
         if (q_msg[26] !== 448'h6161)   begin bad_n++; $display("FAIL directed aa: got %h want 6161", q_msg[26]); end
         if (q_len[26] !== 64'd16)      begin bad_n++; $display("FAIL directed len2: got %0d want 16", q_len[26]); end
         if (q_msg[51] !== 448'h617a)   begin bad_n++; $display("FAIL directed az: got %h want 617a", q_msg[51]); end
         if (q_msg[52] !== 448'h6261)   begin bad_n++; $display("FAIL directed ba: got %h want 6261", q_msg[52]); end
         if (q_msg[701] !== 448'h7a7a)  begin bad_n++; $display("FAIL directed last: got %h want 7a7a", q_msg[701]); end
      end
   endtask

   task automatic test_len1();
      do_reset();
      run_seq(1'b0, 1, 0, -1, 0, 1'b0, 1'b0, "len1");
   endtask

   task automatic test_halt();
      do_reset();
      run_seq(1'b0, 2, 0, 3, 0, 1'b0, 1'b0, "halt_ac");
   endtask

   task automatic test_clamp();
      do_reset();
      run_seq(1'b1, 0, 10, -1, 0, 1'b0, 1'b0, "clamp0");
      run_seq(1'b1, 63, 10, -1, 0, 1'b0, 1'b0, "clamp63");
   endtask

   task automatic test_random();
      do_reset();
      run_seq(1'b0, 3, 25, -1, 0, 1'b0, 1'b1, "rand3");
   endtask

   task automatic test_rst_mid();
      do_reset();
      run_seq(1'b0, 3, 20, -1, 200, 1'b0, 1'b1, "rst_mid");
      run_seq(1'b0, 1, 0, -1, 0, 1'b0, 1'b0, "after_rst");
   endtask

   task automatic test_back_to_back();
      do_reset();
      run_seq(1'b0, 2, 10, -1, 0, 1'b0, 1'b1, "b2b_first");
      run_seq(1'b0, 1, 30, -1, 0, 1'b0, 1'b1, "b2b_restart");
      do_reset();
      run_seq(1'b0, 2, 15, -1, 0, 1'b1, 1'b0, "start_halt");
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; halt = 1'b0; sel = 1'b0; max_len = 6'd0;
      test_reset();
      test_len1();
      test_directed();
      test_halt();
      test_clamp();
      test_random();
      test_rst_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total_n, bad_n);
      $finish;
   end
endmodule
